// File: rtl/chan_sel_pkg.sv
// Shared definitions for the coded channel selector.
package chan_sel_pkg;

  // Select code meaning "no channel".
  localparam int unsigned SEL_NONE = 0;

  // Operating mode encodings.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_SCAN  = 1'b1
  } mode_e;

  // True when code addresses a real channel (1..nch).
  function automatic logic sel_code_ok(input int unsigned code, input int unsigned nch);
    return (code >= 1) && (code <= nch);
  endfunction

endpackage

// File: rtl/scan_ptr.sv
// Round-robin channel pointer over codes 1..NCH, restartable to 1.
module scan_ptr #(
  parameter int unsigned NCH  = 3,
  parameter int unsigned SELW = $clog2(NCH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  input  logic            advance,
  output logic [SELW-1:0] ptr
);

  // Restart wins over advance; wrap NCH back to 1 (NCH=1 stays at 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SELW'(1);
    end else if (restart) begin
      ptr <= SELW'(1);
    end else if (advance) begin
      ptr <= (ptr == SELW'(NCH)) ? SELW'(1) : ptr + SELW'(1);
    end
  end

endmodule

// File: rtl/chan_select_pipe.sv
// Registered NCH-way coded channel selector with fixed and scan modes,
// driving a depth-1 valid/ready output stage.
module chan_select_pipe
  import chan_sel_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned NCH   = 3,
  parameter int unsigned SELW  = $clog2(NCH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 sel_valid,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  sel_q;
  mode_e            mode_q;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  code_c;
  logic [WIDTH-1:0] word_c;
  logic             free_c;
  logic             restart_c;
  logic             advance_c;

  // Latched select code (out-of-range codes collapse to none) and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= SELW'(SEL_NONE);
      mode_q <= MODE_FIXED;
    end else begin
      if (sel_valid) begin
        sel_q <= sel_code_ok(32'(sel), NCH) ? sel : SELW'(SEL_NONE);
      end
      mode_q <= mode_e'(mode);
    end
  end

  assign free_c    = !out_valid || out_ready;
  // Entering scan mode: pointer is 1 when the first scan load happens.
  assign restart_c = (mode_q == MODE_FIXED) && (mode_e'(mode) == MODE_SCAN);
  assign advance_c = free_c && (mode_q == MODE_SCAN);

  scan_ptr #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_scan_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_c),
    .advance (advance_c),
    .ptr     (ptr)
  );

  // Pick the active code and mux out that channel's word (zero for none).
  always_comb begin
    code_c = (mode_q == MODE_SCAN) ? ptr : sel_q;
    word_c = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      if (code_c == SELW'(k)) begin
        word_c = ch_data[(k-1)*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot: loads only when empty or being accepted, else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= SELW'(SEL_NONE);
      out_valid <= 1'b0;
    end else if (free_c) begin
      out_data  <= word_c;
      out_ch    <= code_c;
      out_valid <= (code_c != SELW'(SEL_NONE));
    end
  end

endmodule

// File: tb/tb_chan_select_pipe.sv
// Self-checking bench for chan_select_pipe (NCH=3 and NCH=5 instances).
module tb_chan_select_pipe;

  typedef struct {
    logic [1:0] data;
    logic [1:0] ch;
  } beat_t;

  logic       clk;
  logic       rst_n;

  logic [5:0] ch_data;
  logic [1:0] sel;
  logic       sel_valid;
  logic       mode;
  logic [1:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready;

  logic [9:0] ch_data5;
  logic [2:0] sel5;
  logic       sel_valid5;
  logic       mode5;
  logic [1:0] out_data5;
  logic [2:0] out_ch5;
  logic       out_valid5;
  logic       out_ready5;

  int checks = 0;
  int passed = 0;
  beat_t sb[$];

  chan_select_pipe #(.WIDTH(2), .NCH(3)) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .sel(sel), .sel_valid(sel_valid),
    .mode(mode), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  chan_select_pipe #(.WIDTH(2), .NCH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data5), .sel(sel5), .sel_valid(sel_valid5),
    .mode(mode5), .out_data(out_data5), .out_ch(out_ch5), .out_valid(out_valid5),
    .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume n beats from dut, comparing against the scoreboard, within budget cycles.
  task automatic expect_beats(input int n, input int budget, input string tag);
    int got;
    beat_t e;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL %s_unexpected: got ch=%0d data=%b, want no beat", tag, out_ch, out_data);
        end else begin
          e = sb.pop_front();
          got++;
          if (out_data !== e.data || out_ch !== e.ch)
            $display("FAIL %s_beat%0d: got ch=%0d data=%b, want ch=%0d data=%b",
                     tag, got, out_ch, out_data, e.ch, e.data);
          else passed++;
        end
      end
      step();
    end
    if (got < n) begin
      checks++;
      $display("FAIL %s_timeout: got %0d beats, want %0d", tag, got, n);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    mode = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", out_valid);
    else passed++;
    checks++;
    if (out_data !== 2'b00 || out_ch !== 2'd0)
      $display("FAIL rst_async_out: got ch=%0d data=%b want 0/00", out_ch, out_data);
    else passed++;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 2'b00 || out_ch !== 2'd0)
        $display("FAIL idle_c%0d: got v=%b ch=%0d data=%b want 0/0/00",
                 i, out_valid, out_ch, out_data);
      else passed++;
    end
  endtask

  task automatic test_fixed();
    ch_data = {2'b11, 2'b10, 2'b01};
    out_ready = 1'b1;
    mode = 1'b0;
    sel = 2'd2;
    sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL fixed_latency1: got v=%b want 0", out_valid);
    else passed++;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 2'b10)
      $display("FAIL fixed_latency2: got v=%b ch=%0d data=%b want 1/2/10",
               out_valid, out_ch, out_data);
    else passed++;
    for (int i = 0; i < 4; i++) sb.push_back('{2'b10, 2'd2});
    expect_beats(4, 4, "fixed_hold");
    sel = 2'd0;
    sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2)
      $display("FAIL desel_lat1: got v=%b ch=%0d want 1/2", out_valid, out_ch);
    else passed++;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 2'b00)
      $display("FAIL desel_lat2: got v=%b ch=%0d data=%b want 0/0/00",
               out_valid, out_ch, out_data);
    else passed++;
  endtask

  task automatic test_out_of_range();
    ch_data5 = {2'b10, 2'b01, 2'b11, 2'b00, 2'b01};
    out_ready5 = 1'b1;
    mode5 = 1'b0;
    sel5 = 3'd3;
    sel_valid5 = 1'b1;
    step();
    sel_valid5 = 1'b0;
    step();
    checks++;
    if (out_valid5 !== 1'b1 || out_ch5 !== 3'd3 || out_data5 !== 2'b11)
      $display("FAIL n5_sel3: got v=%b ch=%0d data=%b want 1/3/11",
               out_valid5, out_ch5, out_data5);
    else passed++;
    sel5 = 3'd7;
    sel_valid5 = 1'b1;
    step();
    sel_valid5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid5 !== 1'b0 || out_ch5 !== 3'd0 || out_data5 !== 2'b00)
        $display("FAIL n5_sel7_c%0d: got v=%b ch=%0d data=%b want 0/0/00",
                 i, out_valid5, out_ch5, out_data5);
      else passed++;
    end
  endtask

  task automatic test_scan_wrap();
    out_ready = 1'b1;
    mode = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{2'b01, 2'd1});
      sb.push_back('{2'b10, 2'd2});
      sb.push_back('{2'b11, 2'd3});
    end
    expect_beats(6, 8, "scan_wrap");
  endtask

  task automatic test_backpressure();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2)
      $display("FAIL bp_pre: got v=%b ch=%0d want 1/2", out_valid, out_ch);
    else passed++;
    out_ready = 1'b0;
    ch_data = {2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 2'b10)
        $display("FAIL bp_hold_c%0d: got v=%b ch=%0d data=%b want 1/2/10",
                 i, out_valid, out_ch, out_data);
      else passed++;
    end
    out_ready = 1'b1;
    sb.push_back('{2'b10, 2'd2});
    sb.push_back('{2'b00, 2'd3});
    expect_beats(2, 2, "bp_release");
  endtask

  task automatic test_mode_reentry();
    mode = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 2'b01)
      $display("FAIL reentry_last_scan: got v=%b ch=%0d data=%b want 1/2/01",
               out_valid, out_ch, out_data);
    else passed++;
    mode = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reentry_fixed_gap: got v=%b want 0", out_valid);
    else passed++;
    sb.push_back('{2'b10, 2'd1});
    sb.push_back('{2'b01, 2'd2});
    expect_beats(2, 3, "reentry");
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3)
      $display("FAIL stall_pre: got v=%b ch=%0d want 1/3", out_valid, out_ch);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 2'b00)
      $display("FAIL stall_rst_async: got v=%b ch=%0d data=%b want 0/0/00",
               out_valid, out_ch, out_data);
    else passed++;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    sb.push_back('{2'b10, 2'd1});
    expect_beats(1, 3, "post_rst_scan");
  endtask

  initial begin
    rst_n = 1'b0;
    ch_data = {2'b11, 2'b10, 2'b01};
    sel = '0;
    sel_valid = 1'b0;
    mode = 1'b0;
    out_ready = 1'b0;
    ch_data5 = '0;
    sel5 = '0;
    sel_valid5 = 1'b0;
    mode5 = 1'b0;
    out_ready5 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    mode = 1'b1;
    repeat (4) step();

    test_reset();
    test_fixed();
    test_out_of_range();
    test_scan_wrap();
    test_backpressure();
    test_mode_reentry();
    test_reset_mid_stall();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/chan_select_pipe.md
Name: chan_select_pipe

Overview:
Parametrised, registered successor of the team's 3-way coded selector.
- NCH data channels, each WIDTH bits, addressed by codes 1..NCH; code 0 selects nothing and drives zero.
- Two modes: fixed (latched select code) and scan (round-robin through all channels).
- Output is a registered valid/ready stream, so it sits between the compare datapath and a downstream consumer that can stall.

Parameters:
- WIDTH, 2, bits per channel and per output word.
- NCH, 3, number of selectable channels, minimum 1. Codes 1..NCH are valid.
- SELW, $clog2(NCH+1), width of select and channel-tag fields. Derived; do not override.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ch_data  in  NCH*WIDTH  channel k (1-based) occupies bits [k*WIDTH-1 : (k-1)*WIDTH].
- sel  in  SELW  select code for fixed mode.
- sel_valid  in  1  loads sel into sel_q on this edge.
- mode  in  1  0 = fixed, 1 = scan. Sampled every cycle into mode_q.
- out_data  out  WIDTH  selected word, registered.
- out_ch  out  SELW  channel code that produced out_data; 0 when no channel.
- out_valid  out  1  out_data/out_ch hold a beat.
- out_ready  in  1  consumer accepts the beat this cycle.

Behaviour:
- Reset (async assert, sync release). Values: sel_q=0, mode_q=0, ptr=1, out_data=0, out_ch=0, out_valid=0.
- sel_q: on sel_valid, sel_q <= sel.
  - Codes > NCH are stored as 0.
  - sel_valid is honoured in both modes; the stored value is used only in fixed mode.
- Slot free: free = !out_valid || out_ready. Output registers load only when free=1.
- Stall: while out_valid && !out_ready:
  - out_data, out_ch and out_valid are held stable.
  - ptr does not advance.
  - Changes to ch_data and sel are not reflected until the slot frees.
- Fixed mode (mode_q=0), when free:
  - sel_q != 0: out_data <= ch_data[sel_q], out_ch <= sel_q, out_valid <= 1.
  - sel_q == 0: out_data <= 0, out_ch <= 0, out_valid <= 0.
- Scan mode (mode_q=1), when free:
  - out_data <= ch_data[ptr], out_ch <= ptr, out_valid <= 1.
  - ptr advances: ptr <= (ptr==NCH) ? 1 : ptr+1.
  - NCH=1: ptr stays 1.
- Mode entry: when mode_q transitions 0->1, ptr is forced to 1 for the first scan load.
  - This takes priority over advance.
  - Switching 1->0 leaves ptr untouched; it is reset on the next entry.
- Latency:
  - sel presented with sel_valid at edge k; that channel's word is in out_data after edge k+1 (2 cycles), given the slot is free.
  - mode is likewise registered, so a mode change affects the load at edge k+1.
- Pending beat at deselect: if a beat is pending and sel_q becomes 0, the pending beat stays until accepted. out_valid then falls on the accepting edge.
- Reset mid-stall: the pending beat is discarded, and all outputs return to reset values immediately (async).
- ch_data sampling: ch_data is sampled only at load edges. There is no other data buffering (depth 1).

Decomposition:
- Shared package chan_sel_pkg:
  - SEL_NONE = 0.
  - Mode encodings MODE_FIXED = 0, MODE_SCAN = 1.
  - Helper function sel_code_ok(code, nch) returning code in 1..nch.
- Sub-module scan_ptr (parameter NCH):
  - Inputs: clk, rst_n, restart, advance.
  - Output: ptr[SELW].
  - Wraps NCH->1.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run, then release with NCH=3, WIDTH=2 and sel never loaded -> out_valid=0, out_data=0, out_ch=0 for 10 cycles.
- Fixed select: ch_data={3:2'b11, 2:2'b10, 1:2'b01}, sel=2 with sel_valid pulse, out_ready=1 -> two cycles later out_data=2'b10, out_ch=2, out_valid=1 and held every cycle; sel=0 -> out_valid=0, out_data=0 two cycles later.
- Out-of-range code: NCH=3, SELW=2 cannot encode >3, so rerun with NCH=5 (SELW=3) and sel=7 -> treated as 0, out_valid=0.
- Scan wrap: mode=1, out_ready=1, NCH=3 -> out_ch sequence 1,2,3,1,2,3 on consecutive cycles, out_data matching each channel.
- Backpressure: scan mode, drop out_ready for 4 cycles while out_ch=2 and change ch_data -> out_data/out_ch frozen at channel 2's old word; on out_ready=1 next beat is ch 3.
- Mode re-entry and reset mid-stall:
  - Scan to ch 2, switch to fixed then back to scan -> first scan beat out_ch=1.
  - Assert rst_n while out_valid=1 and out_ready=0 -> out_valid drops immediately without waiting for clk.
